// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the UART <-> AES command sequencer.
// Holds the sequencer state encoding, the protocol bytes and the block size.
package aes_uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_KEY,
    ST_RX_PT,
    ST_AES_GO,
    ST_AES_WAIT,
    ST_TX_SEND,
    ST_TX_WAIT,
    ST_RESP_SEND,
    ST_RESP_WAIT
  } state_t;

  localparam logic [7:0] CMD_KEY  = 8'h6B;
  localparam logic [7:0] CMD_PT   = 8'h70;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int BLOCK_BYTES = 16;

  // Frames arrive MSB byte first, so each new byte enters at the bottom.
  function automatic logic [127:0] shift_in_byte(input logic [127:0] a_Reg,
                                                 input logic [7:0]   a_Byte);
    return {a_Reg[119:0], a_Byte};
  endfunction

endpackage

// File: rtl/uart_aes_ctrl_if.sv
// Bundle of the UART byte handshake and AES core signals seen by the sequencer.
// master = the sequencer, slave = the UART/AES environment around it.
interface uart_aes_ctrl_if;
  logic         i_RX_DV;
  logic [7:0]   i_RX_Byte;
  logic         o_TX_DV;
  logic [7:0]   o_TX_Byte;
  logic         i_TX_Active;
  logic         i_TX_Done;
  logic [127:0] o_Key;
  logic [127:0] o_Plaintext;
  logic         o_AES_Start;
  logic         i_AES_Done;
  logic [127:0] i_Ciphertext;
  logic         o_Trigger;
  logic         o_Busy;

  modport master (
    input  i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done, i_AES_Done, i_Ciphertext,
    output o_TX_DV, o_TX_Byte, o_Key, o_Plaintext, o_AES_Start, o_Trigger, o_Busy
  );

  modport slave (
    output i_RX_DV, i_RX_Byte, i_TX_Active, i_TX_Done, i_AES_Done, i_Ciphertext,
    input  o_TX_DV, o_TX_Byte, o_Key, o_Plaintext, o_AES_Start, o_Trigger, o_Busy
  );
endinterface

// File: rtl/uart_aes_ctrl_sender.sv
// One-byte UART transmit handshake: launch when the transmitter is idle,
// then report completion on its done strobe. Shared by ciphertext and ACK/NAK.
module uart_byte_sender (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Send,
  input  logic       i_Wait,
  input  logic [7:0] i_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic       o_Launch,
  output logic       o_Sent,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte
);

  logic       r_TX_DV;
  logic [7:0] r_TX_Byte;

  assign o_Launch = i_Send & ~i_TX_Active;
  assign o_Sent   = i_Wait & i_TX_Done;

  // The byte register only updates on launch so it holds between strobes.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_TX_DV   <= 1'b0;
      r_TX_Byte <= 8'h00;
    end else begin
      r_TX_DV <= o_Launch;
      if (o_Launch) r_TX_Byte <= i_Byte;
    end
  end

  assign o_TX_DV   = r_TX_DV;
  assign o_TX_Byte = r_TX_Byte;

endmodule

// File: rtl/uart_aes_ctrl.sv
// Host command sequencer: parses 'k'/'p' frames from the UART, runs one AES
// encryption per plaintext and streams the ciphertext back, with a scope trigger.
module uart_aes_ctrl
  import aes_uart_pkg::*;
#(
  parameter int RX_TIMEOUT = 8680
) (
  input logic             i_Clk,
  input logic             i_Rst_n,
  uart_aes_ctrl_if.master bus
);

  localparam int         TW   = $clog2(RX_TIMEOUT + 1);
  localparam logic [4:0] LAST = 5'(BLOCK_BYTES - 1);

  state_t         r_State;
  logic [4:0]     r_Cnt;
  logic [TW-1:0]  r_Tout;
  logic [127:0]   r_Key;
  logic [127:0]   r_Key_Shadow;
  logic [127:0]   r_Plaintext;
  logic [127:0]   r_Shift;
  logic [7:0]     r_Resp;
  logic           r_Start;
  logic           r_Trigger;

  logic           w_Send;
  logic           w_Wait;
  logic [7:0]     w_TX_Byte;
  logic           w_Launch;
  logic           w_Sent;
  logic           w_Last;

  assign w_Send    = (r_State == ST_TX_SEND) || (r_State == ST_RESP_SEND);
  assign w_Wait    = (r_State == ST_TX_WAIT) || (r_State == ST_RESP_WAIT);
  assign w_TX_Byte = (r_State == ST_RESP_SEND) ? r_Resp : r_Shift[127:120];
  assign w_Last    = (r_Cnt == LAST);

  uart_byte_sender u_sender (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Send      (w_Send),
    .i_Wait      (w_Wait),
    .i_Byte      (w_TX_Byte),
    .i_TX_Active (bus.i_TX_Active),
    .i_TX_Done   (bus.i_TX_Done),
    .o_Launch    (w_Launch),
    .o_Sent      (w_Sent),
    .o_TX_DV     (bus.o_TX_DV),
    .o_TX_Byte   (bus.o_TX_Byte)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State      <= ST_IDLE;
      r_Cnt        <= '0;
      r_Tout       <= '0;
      r_Key        <= '0;
      r_Key_Shadow <= '0;
      r_Plaintext  <= '0;
      r_Shift      <= '0;
      r_Resp       <= 8'h00;
      r_Start      <= 1'b0;
      r_Trigger    <= 1'b0;
    end else begin
      r_Start <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          if (bus.i_RX_DV) begin
            r_Cnt  <= '0;
            r_Tout <= '0;
            if (bus.i_RX_Byte == CMD_KEY)     r_State <= ST_RX_KEY;
            else if (bus.i_RX_Byte == CMD_PT) r_State <= ST_RX_PT;
            else begin
              r_Resp  <= NAK_BYTE;
              r_State <= ST_RESP_SEND;
            end
          end
        end

        // The key is assembled in a shadow so an aborted frame leaves o_Key intact.
        ST_RX_KEY, ST_RX_PT: begin
          if (bus.i_RX_DV) begin
            r_Tout <= '0;
            r_Cnt  <= r_Cnt + 5'd1;
            if (r_State == ST_RX_KEY) r_Key_Shadow <= shift_in_byte(r_Key_Shadow, bus.i_RX_Byte);
            else                      r_Plaintext  <= shift_in_byte(r_Plaintext, bus.i_RX_Byte);
            if (w_Last) begin
              if (r_State == ST_RX_KEY) begin
                r_Key   <= shift_in_byte(r_Key_Shadow, bus.i_RX_Byte);
                r_Resp  <= ACK_BYTE;
                r_State <= ST_RESP_SEND;
              end else begin
                r_Start   <= 1'b1;
                r_Trigger <= 1'b1;
                r_State   <= ST_AES_GO;
              end
            end
          end else if (r_Tout == TW'(RX_TIMEOUT - 1)) begin
            r_Resp  <= NAK_BYTE;
            r_State <= ST_RESP_SEND;
          end else begin
            r_Tout <= r_Tout + TW'(1);
          end
        end

        ST_AES_GO: r_State <= ST_AES_WAIT;

        ST_AES_WAIT: begin
          if (bus.i_AES_Done) begin
            r_Shift   <= bus.i_Ciphertext;
            r_Trigger <= 1'b0;
            r_Cnt     <= '0;
            r_State   <= ST_TX_SEND;
          end
        end

        ST_TX_SEND: if (w_Launch) r_State <= ST_TX_WAIT;

        ST_TX_WAIT: begin
          if (w_Sent) begin
            r_Shift <= {r_Shift[119:0], 8'h00};
            r_Cnt   <= r_Cnt + 5'd1;
            r_State <= w_Last ? ST_IDLE : ST_TX_SEND;
          end
        end

        ST_RESP_SEND: if (w_Launch) r_State <= ST_RESP_WAIT;

        ST_RESP_WAIT: if (w_Sent) r_State <= ST_IDLE;

        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_Key       = r_Key;
  assign bus.o_Plaintext = r_Plaintext;
  assign bus.o_AES_Start = r_Start;
  assign bus.o_Trigger   = r_Trigger;
  assign bus.o_Busy      = (r_State != ST_IDLE);

endmodule

// File: tb/tb_uart_aes_ctrl.sv
// Bench for uart_aes_ctrl: directed host frames, UART/AES responder models and a
// scoreboard monitor that checks every transmitted byte and the trigger window.
module tb_uart_aes_ctrl;

  localparam int           RX_TO = 8680;
  localparam logic [127:0] CT    = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] KEY1  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KEY2  = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] PT1   = 128'h1112131415161718191A1B1C1D1E1F20;

  logic i_Clk = 1'b0;
  logic i_Rst_n = 1'b0;

  uart_aes_ctrl_if bus ();

  uart_aes_ctrl #(.RX_TIMEOUT(RX_TO)) dut (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_tx = 0;
  int         n_start = 0;
  logic [7:0] exp_q[$];
  logic       exp_trig = 1'b0;
  logic       prev_start = 1'b0;
  logic       prev_active = 1'b0;
  logic       tx_pending = 1'b0;
  logic       aes_done_m = 1'b0;
  logic       aes_done_s = 1'b0;
  logic       uart_slow = 1'b0;

  assign bus.i_AES_Done   = aes_done_m | aes_done_s;
  assign bus.i_Ciphertext = CT;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge i_Clk) begin
    if (!i_Rst_n) begin
      exp_trig    = 1'b0;
      prev_start  = 1'b0;
      prev_active = 1'b0;
      tx_pending  = 1'b0;
    end else begin
      if (bus.o_AES_Start) begin
        n_start++;
        exp_trig = 1'b1;
        check("start_one_cycle", {127'd0, prev_start}, 128'd0);
      end
      check("trigger", {127'd0, bus.o_Trigger}, {127'd0, exp_trig});
      if (bus.i_AES_Done) exp_trig = 1'b0;
      prev_start = bus.o_AES_Start;
      if (bus.o_TX_DV) begin
        n_tx++;
        check("tx_after_done", {127'd0, tx_pending}, 128'd0);
        check("tx_while_active", {127'd0, prev_active}, 128'd0);
        tx_pending = 1'b1;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %h, no byte expected", bus.o_TX_Byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("tx_byte", {120'd0, bus.o_TX_Byte}, {120'd0, e});
        end
      end
      if (bus.i_TX_Done) tx_pending = 1'b0;
      prev_active = bus.i_TX_Active;
    end
  end

  // UART transmitter model; every other byte keeps TX_Active high past Done.
  initial begin
    bus.i_TX_Active = 1'b0;
    bus.i_TX_Done   = 1'b0;
    forever begin
      @(negedge i_Clk);
      if (bus.o_TX_DV && i_Rst_n) begin
        @(posedge i_Clk); #1 bus.i_TX_Active = 1'b1;
        repeat (5) @(posedge i_Clk);
        #1 bus.i_TX_Done = 1'b1;
        if (!uart_slow) bus.i_TX_Active = 1'b0;
        @(posedge i_Clk); #1 bus.i_TX_Done = 1'b0;
        if (uart_slow) begin
          @(posedge i_Clk); #1 bus.i_TX_Active = 1'b0;
        end
        uart_slow = ~uart_slow;
      end
    end
  end

  // AES core model: done ten cycles after start.
  initial begin
    forever begin
      @(negedge i_Clk);
      if (bus.o_AES_Start && i_Rst_n) begin
        repeat (10) @(posedge i_Clk);
        #1 aes_done_m = 1'b1;
        @(posedge i_Clk); #1 aes_done_m = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_Clk); #1 bus.i_RX_DV = 1'b1; bus.i_RX_Byte = b;
    @(posedge i_Clk); #1 bus.i_RX_DV = 1'b0;
  endtask

  task automatic push_ct();
    logic [127:0] t;
    t = CT;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(t[127:120]);
      t = t << 8;
    end
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int k;
    k = 0;
    while ((bus.o_Busy || exp_q.size() != 0) && k < maxc) begin
      @(posedge i_Clk); #1;
      k++;
    end
    check(name, {127'd0, (k < maxc)}, 128'd1);
  endtask

  task automatic run_pt(input bit disturb, input logic [127:0] key_exp);
    int s0;
    int t0;
    s0 = n_start;
    t0 = n_tx;
    push_ct();
    send_byte(8'h70);
    for (int i = 0; i < 15; i++) send_byte(8'(8'h11 + i));
    send_byte(8'h20);
    @(negedge i_Clk);
    check("start_latency", {127'd0, bus.o_AES_Start}, 128'd1);
    check("plaintext", bus.o_Plaintext, PT1);
    if (disturb) begin
      fork
        wait_idle("pt_stream_done", 600);
        begin
          repeat (3) @(posedge i_Clk);
          send_byte(8'h6B);
          for (int i = 0; i < 4; i++) begin
            repeat (20) @(posedge i_Clk);
            send_byte(8'h41);
          end
        end
      join
    end else begin
      wait_idle("pt_stream_done", 600);
    end
    check("start_count", 128'(n_start), 128'(s0 + 1));
    check("ct_byte_count", 128'(n_tx), 128'(t0 + 16));
    check("key_kept_pt", bus.o_Key, key_exp);
  endtask

  initial begin
    int t0;
    int k;
    bus.i_RX_DV   = 1'b0;
    bus.i_RX_Byte = 8'h00;
    repeat (3) @(posedge i_Clk);
    #1;
    check("rst_tx_dv", {127'd0, bus.o_TX_DV}, 128'd0);
    check("rst_tx_byte", {120'd0, bus.o_TX_Byte}, 128'd0);
    check("rst_key", bus.o_Key, 128'd0);
    check("rst_pt", bus.o_Plaintext, 128'd0);
    check("rst_start", {127'd0, bus.o_AES_Start}, 128'd0);
    check("rst_trigger", {127'd0, bus.o_Trigger}, 128'd0);
    check("rst_busy", {127'd0, bus.o_Busy}, 128'd0);
    @(negedge i_Clk) i_Rst_n = 1'b1;

    // Key load with ACK latency
    exp_q.push_back(8'h06);
    send_byte(8'h6B);
    for (int i = 0; i < 15; i++) send_byte(8'(i));
    send_byte(8'h0F);
    @(negedge i_Clk);
    check("ack_lat_c1", {127'd0, bus.o_TX_DV}, 128'd0);
    @(negedge i_Clk);
    check("ack_lat_c2", {127'd0, bus.o_TX_DV}, 128'd1);
    wait_idle("key_ack_done", 100);
    check("key1", bus.o_Key, KEY1);
    check("no_start_on_key", 128'(n_start), 128'd0);

    // Plaintext and encryption
    run_pt(1'b0, KEY1);

    // Unknown command, then a stray AES done in IDLE
    exp_q.push_back(8'h15);
    send_byte(8'h41);
    wait_idle("nak_cmd_done", 100);
    check("key_after_nak", bus.o_Key, KEY1);
    @(posedge i_Clk); #1 aes_done_s = 1'b1;
    @(posedge i_Clk); #1 aes_done_s = 1'b0;
    repeat (5) @(posedge i_Clk);
    #1;
    check("stray_done_busy", {127'd0, bus.o_Busy}, 128'd0);

    // Timed-out key frame
    exp_q.push_back(8'h15);
    send_byte(8'h6B);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hAA + i));
    t0 = n_tx;
    repeat (RX_TO - 2) @(posedge i_Clk);
    #1;
    check("timeout_not_early", 128'(n_tx), 128'(t0));
    check("timeout_busy", {127'd0, bus.o_Busy}, 128'd1);
    wait_idle("timeout_nak_done", 40);
    check("key_restored", bus.o_Key, KEY1);
    exp_q.push_back(8'h06);
    send_byte(8'h6B);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
    wait_idle("key2_ack_done", 100);
    check("key2", bus.o_Key, KEY2);

    // Bytes injected during AES_WAIT and streaming are dropped
    run_pt(1'b1, KEY2);

    // Reset in the middle of the ciphertext stream
    push_ct();
    t0 = n_tx;
    send_byte(8'h70);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h11 + i));
    k = 0;
    while (n_tx < t0 + 8 && k < 500) begin
      @(posedge i_Clk);
      k++;
    end
    check("reached_8th_byte", 128'(n_tx), 128'(t0 + 8));
    @(posedge i_Clk); #3 i_Rst_n = 1'b0;
    #1;
    check("mid_rst_tx_dv", {127'd0, bus.o_TX_DV}, 128'd0);
    check("mid_rst_tx_byte", {120'd0, bus.o_TX_Byte}, 128'd0);
    check("mid_rst_key", bus.o_Key, 128'd0);
    check("mid_rst_pt", bus.o_Plaintext, 128'd0);
    check("mid_rst_start", {127'd0, bus.o_AES_Start}, 128'd0);
    check("mid_rst_trigger", {127'd0, bus.o_Trigger}, 128'd0);
    check("mid_rst_busy", {127'd0, bus.o_Busy}, 128'd0);
    exp_q.delete();
    t0 = n_tx;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk) i_Rst_n = 1'b1;
    repeat (40) @(posedge i_Clk);
    #1;
    check("no_tx_after_rst", 128'(n_tx), 128'(t0));
    check("idle_after_rst", {127'd0, bus.o_Busy}, 128'd0);
    run_pt(1'b0, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_aes_ctrl.md
Name: uart_aes_ctrl

Overview:
- Command sequencer between the UART byte receiver/transmitter pair and the AES core.
- Parses host commands arriving as RX bytes and loads a 128-bit key or plaintext.
- Starts one encryption, captures the ciphertext and streams it back through the UART transmitter, one byte per TX handshake.
- Drives a scope trigger that brackets the encryption for side-channel capture.

Parameters:
- RX_TIMEOUT, 8680, idle clocks allowed between bytes of a frame before the frame is aborted (about 4 byte times at 25 MHz / 115200).
- CMD_KEY, 8'h6B, command byte 'k': the next 16 bytes are the key.
- CMD_PT, 8'h70, command byte 'p': the next 16 bytes are the plaintext, then encrypt.
- ACK_BYTE, 8'h06, response sent after a successful key load.
- NAK_BYTE, 8'h15, response sent for an unknown command or a timed-out frame.

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte is valid
- i_RX_Byte  in  8  received byte
- o_TX_DV  out  1  one-cycle strobe: transmit o_TX_Byte
- o_TX_Byte  out  8  byte to transmit
- i_TX_Active  in  1  transmitter busy
- i_TX_Done  in  1  one-cycle strobe: byte transmission finished
- o_Key  out  128  key register
- o_Plaintext  out  128  plaintext register
- o_AES_Start  out  1  one-cycle encryption start pulse
- i_AES_Done  in  1  one-cycle strobe: i_Ciphertext is valid
- i_Ciphertext  in  128  AES result
- o_Trigger  out  1  high from the start pulse through the done cycle
- o_Busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, i_Rst_n low): state IDLE.
  - Outputs: o_TX_DV=0, o_TX_Byte=0, o_Key=0, o_Plaintext=0, o_AES_Start=0, o_Trigger=0, o_Busy=0.
  - Byte counter, timeout counter and ciphertext shift register all cleared.
  - Reset mid-frame or mid-encryption discards everything; no response byte is sent.
- States: IDLE, RX_KEY, RX_PT, AES_GO, AES_WAIT, TX_SEND, TX_WAIT, RESP_SEND, RESP_WAIT.
- IDLE, on i_RX_DV:
  - CMD_KEY -> RX_KEY.
  - CMD_PT -> RX_PT.
  - Any other byte -> RESP_SEND with NAK_BYTE.
  - Byte counter is cleared on entry to RX_KEY or RX_PT.
- RX_KEY / RX_PT:
  - Each i_RX_DV shifts the byte into the LSB end of the target register; the previous contents move up 8 bits. The first data byte therefore ends in bits [127:120].
  - Each i_RX_DV increments the counter and clears the timeout counter.
  - On the 16th byte: RX_KEY -> RESP_SEND with ACK_BYTE; RX_PT -> AES_GO.
  - Timeout counter increments on cycles without i_RX_DV. Reaching RX_TIMEOUT -> RESP_SEND with NAK_BYTE.
  - On a timed-out key load, the partially loaded o_Key is restored to its value before the frame. The key uses a shadow register and commits only on the 16th byte.
  - On a timed-out plaintext frame, o_Plaintext may hold partial data.
- AES_GO:
  - o_AES_Start=1 and o_Trigger set, both in the same cycle.
  - Next cycle -> AES_WAIT. Start is exactly one cycle wide.
- AES_WAIT, on i_AES_Done:
  - Capture i_Ciphertext into the shift register and clear o_Trigger on the following edge.
  - Clear the counter, then -> TX_SEND.
  - A done pulse outside AES_WAIT is ignored.
- TX_SEND:
  - When i_TX_Active=0, assert o_TX_DV for one cycle with o_TX_Byte = shift[127:120], then -> TX_WAIT.
  - While i_TX_Active=1, stay in TX_SEND with o_TX_DV held low.
- TX_WAIT, on i_TX_Done:
  - Shift left by 8 and increment the counter.
  - After the 16th byte -> IDLE, otherwise -> TX_SEND.
  - Ciphertext goes out MSB byte first.
- RESP_SEND / RESP_WAIT: same handshake as TX_SEND / TX_WAIT for a single byte, then -> IDLE.
- Overflow: i_RX_DV in AES_GO, AES_WAIT, TX_*, RESP_* is dropped silently. It does not restart the frame parser.
- o_TX_Byte holds its last value when o_TX_DV=0.
- Latency, measured from the i_RX_DV edge:
  - 16th plaintext byte to o_AES_Start: 1 cycle.
  - i_AES_Done to the first o_TX_DV: 2 cycles (if TX is idle).
  - 16th key byte to the ACK o_TX_DV: 2 cycles.
- o_Trigger cannot be re-asserted until the full 16-byte response has been sent.

Decomposition:
- Shared package aes_uart_pkg holds:
  - the state enum;
  - CMD_KEY, CMD_PT, ACK_BYTE, NAK_BYTE;
  - BLOCK_BYTES=16.
- One natural sub-module: uart_byte_sender. It handles the TX_SEND/TX_WAIT handshake and is reused for both the ciphertext stream and the single response byte. All other logic stays flat.

Test Plan:
- 'k' + bytes 00..0F -> o_Key=128'h000102030405060708090A0B0C0D0E0F; exactly one o_TX_DV with byte 8'h06; o_AES_Start never pulses.
- Key loaded as above, then 'p' + 16 bytes 11..; model returns i_AES_Done 10 cycles later with i_Ciphertext=128'h69C4E0D86A7B0430D8CDB78070B4C55A -> one-cycle o_AES_Start; o_Trigger high exactly start..done; 16 TX bytes 69,C4,...,5A in order, each o_TX_DV only after the previous i_TX_Done.
- Command 8'h41 -> single TX byte 8'h15; return to IDLE; o_Key unchanged.
- 'k' + 5 bytes, then silence for RX_TIMEOUT cycles -> TX byte 8'h15; o_Key equals its pre-frame value; the next 'k' frame loads correctly.
- RX bytes injected during AES_WAIT and TX streaming -> dropped; output stream identical to the undisturbed case; no NAK.
- i_Rst_n low during the 8th ciphertext byte -> all outputs zero immediately; o_TX_DV stays 0 after release; a fresh 'p' frame encrypts normally.
